rv32i_encoder: RTL
==================

// Module: rv32i_encoder
// PURPOSE
//  Inverse of the RV32I instruction decoder: accepts decoded instruction fields over a valid/ready
//  handshake and emits 32-bit RV32I instruction words over a second valid/ready handshake.
//  Range-checks immediates and funct codes, and expands the LI pseudo-op into LUI+ADDI when needed.
//  Sits between the test/boot program generator and the instruction memory writer.
// PARAMETERS
//  COUNT_W  16  width of insn_count (emitted-word counter, wraps)
//  LI_EN    1   1: kind 9 (LI) is legal; 0: kind 9 is reported as err_code 1
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst          in   1   reset, synchronous, active-high
//  in_valid     in   1   request fields valid
//  in_ready     out  1   encoder can accept a request this cycle
//  in_kind      in   4   0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OPIMM,8 OP,9 LI
//  in_funct3    in   3   funct3 (ignored for LUI/AUIPC/JAL/LI; must be 000 for JALR)
//  in_alt       in   1   funct7[5] (SUB/SRA/SRAI); must be 0 elsewhere
//  in_rd,in_rs1,in_rs2  in  5 each  register indices
//  in_imm       in   32  full immediate value (byte offset for JAL/BRANCH; LUI/AUIPC: upper bits in place)
//  out_valid    out  1   out_insn valid
//  out_ready    in   1   consumer takes out_insn when out_valid&out_ready
//  out_insn     out  32  encoded instruction word
//  out_last     out  1   word is the final word of its request
//  err_valid    out  1   one-cycle pulse: accepted request rejected
//  err_code     out  3   1 bad kind, 2 bad funct3/alt, 3 imm out of range, 4 imm misaligned
//  insn_count   out  COUNT_W  number of out handshakes since reset, modulo 2^COUNT_W
// BEHAVIOUR
//  Reset: out_valid=0, out_insn=0, out_last=0, err_valid=0, err_code=0, insn_count=0, state=IDLE.
//  States: IDLE, LI_LO. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Accept (in_valid&in_ready) in IDLE: next cycle either out_valid=1 with the word (latency 1), or err_valid=1
//   with err_code and no word. Request is consumed either way. Check order: kind, funct, range, alignment.
//  Legal funct3: BRANCH not 010/011; LOAD 000,001,010,100,101; STORE 000,001,010; alt=1 only OP 000/101 and
//   OPIMM 101; OPIMM 001 requires alt=0.
//  Imm rules: LUI/AUIPC imm[11:0]==0; JAL signed 21b, imm[0]==0; BRANCH signed 13b, imm[0]==0;
//   JALR/LOAD/STORE/ADDI/SLTI signed 12b (imm[31:11] all equal); SLTIU/XORI/ORI/ANDI 0..4095 (zero-extended
//   form); SLLI/SRLI/SRAI imm[31:5]==0; OP ignores in_imm.
//  LI: imm signed 12b -> single ADDI rd,x0,imm (out_last=1). Else hi=imm[31:12]+imm[11] (mod 2^20):
//   emit LUI rd,hi (out_last=1 if imm[11:0]==0, else 0 and go to LI_LO). LI_LO holds rd/imm[11:0]; when
//   output slot frees, emit ADDI rd,rd,sext(imm[11:0]) with out_last=1, return IDLE. in_ready=0 in LI_LO.
//  Output hold: while out_valid&~out_ready, out_insn/out_last stable. New word loads same cycle as handshake.
//  insn_count +1 on each out handshake, wraps to 0 from all-ones. Errors do not count.
//  rd=x0 is legal (encoded as given). Reset mid-LI: pending second word discarded, state IDLE.
// TESTING
//  ADDI x5,x0,-1 (kind7,f3 000,imm 0xFFFFFFFF) -> out_insn 0xFFF00293, out_last 1, one cycle later.
//  LI x10,0x12345FFF with out_ready=1 -> 0x12346537 (last 0) then 0xFFF50513 (last 1); count +2.
//  JAL x1,+8 -> 0x008000EF; BEQ x1,x2,+16 -> 0x00208863; SW x2,4(x1) -> 0x0020A223.
//  ADDI imm 2048 -> err_code 3, no out_valid; BEQ imm 3 -> err_code 4; kind 12 -> err_code 1.
//  LI with out_ready low 3 cycles -> LUI word stable, in_ready 0, count unchanged until handshake.
//  rst asserted in LI_LO -> next cycle out_valid 0, count 0, ADDI word never emitted.

Source files
------------

// File: rtl/rv32i_encoder.sv
// rv32i_encoder: turns decoded RV32I instruction fields into 32-bit instruction words.
// Checks each request and reports the first problem it finds, in this order: kind, funct, immediate
// range, immediate alignment. Expands the LI pseudo-op into a single ADDI, or into LUI followed by ADDI.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready request handshake; in_ready is combinational
//   in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm   decoded fields
//   out_valid/out_ready, out_insn, out_last   word handshake (registered outputs)
//   err_valid, err_code   one-cycle reject pulse and reason (1 kind, 2 funct, 3 range, 4 align)
//   insn_count            output handshakes since reset, wraps
module rv32i_encoder #(
  parameter int unsigned COUNT_W = 16,
  parameter bit          LI_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_kind,
  input  logic [2:0]         in_funct3,
  input  logic               in_alt,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_insn,
  output logic               out_last,
  output logic               err_valid,
  output logic [2:0]         err_code,
  output logic [COUNT_W-1:0] insn_count
);

  localparam int unsigned INSN_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned LO_W   = 12;
  localparam int unsigned HI_W   = 20;

  localparam logic [3:0] K_LUI    = 4'd0;
  localparam logic [3:0] K_AUIPC  = 4'd1;
  localparam logic [3:0] K_JAL    = 4'd2;
  localparam logic [3:0] K_JALR   = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_LOAD   = 4'd5;
  localparam logic [3:0] K_STORE  = 4'd6;
  localparam logic [3:0] K_OPIMM  = 4'd7;
  localparam logic [3:0] K_OP     = 4'd8;
  localparam logic [3:0] K_LI     = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_KIND  = 3'd1;
  localparam logic [2:0] E_FUNCT = 3'd2;
  localparam logic [2:0] E_RANGE = 3'd3;
  localparam logic [2:0] E_ALIGN = 3'd4;

  typedef enum logic [0:0] {S_IDLE, S_LI_LO} state_t;

  state_t             state_q, state_d;
  logic [REG_W-1:0]   li_rd_q, li_rd_d;
  logic [LO_W-1:0]    li_lo_q, li_lo_d;
  logic               out_valid_d, out_last_d, err_valid_d;
  logic [INSN_W-1:0]  out_insn_d;
  logic [2:0]         err_code_d;
  logic [COUNT_W-1:0] count_d;

  // Immediate range classes; "sext N" means the value fits in N signed bits.
  logic sext12_ok, sext13_ok, sext21_ok, zext12_ok, shamt_ok;
  assign sext12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign sext13_ok = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign sext21_ok = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
  assign zext12_ok = (in_imm[31:12] == '0);
  assign shamt_ok  = (in_imm[31:5]  == '0);

  logic              slot_free;
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q == S_IDLE) && slot_free;

  // Request decode: validity checks and the first (or only) word to emit.
  logic              kind_ok, funct_ok, range_ok, align_ok;
  logic [2:0]        req_err;
  logic [INSN_W-1:0] enc_insn;
  logic              enc_last, enc_split;
  logic [HI_W-1:0]   li_hi;
  logic              is_shift;

  always_comb begin
    kind_ok   = 1'b1;
    funct_ok  = 1'b1;
    range_ok  = 1'b1;
    align_ok  = 1'b1;
    enc_insn  = '0;
    enc_last  = 1'b1;
    enc_split = 1'b0;
    // Round up when the low part will be sign-extended negative by the ADDI.
    li_hi     = in_imm[31:12] + HI_W'(in_imm[11]);
    is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    case (in_kind)
      K_LUI, K_AUIPC: begin
        funct_ok = !in_alt;
        range_ok = (in_imm[11:0] == '0);
        enc_insn = {in_imm[31:12], in_rd, (in_kind == K_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      K_JAL: begin
        funct_ok = !in_alt;
        range_ok = sext21_ok;
        align_ok = !in_imm[0];
        enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      K_JALR: begin
        funct_ok = !in_alt && (in_funct3 == 3'b000);
        range_ok = sext12_ok;
        enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
      end
      K_BRANCH: begin
        funct_ok = !in_alt && (in_funct3 != 3'b010) && (in_funct3 != 3'b011);
        range_ok = sext13_ok;
        align_ok = !in_imm[0];
        enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
                    OPC_BRANCH};
      end
      K_LOAD: begin
        funct_ok = !in_alt && (in_funct3 != 3'b011) && (in_funct3 != 3'b110) &&
                   (in_funct3 != 3'b111);
        range_ok = sext12_ok;
        enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      end
      K_STORE: begin
        funct_ok = !in_alt && (in_funct3[2] == 1'b0) && (in_funct3 != 3'b011);
        range_ok = sext12_ok;
        enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      end
      K_OPIMM: begin
        funct_ok = !in_alt || (in_funct3 == 3'b101);
        case (in_funct3)
          3'b000, 3'b010: range_ok = sext12_ok;
          3'b001, 3'b101: range_ok = shamt_ok;
          default:        range_ok = zext12_ok;
        endcase
        if (is_shift) begin
          enc_insn = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
        end else begin
          enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
        end
      end
      K_OP: begin
        funct_ok = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
        enc_insn = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
      end
      K_LI: begin
        kind_ok  = LI_EN;
        funct_ok = !in_alt;
        if (sext12_ok) begin
          enc_insn = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OPIMM};
        end else begin
          enc_insn  = {li_hi, in_rd, OPC_LUI};
          enc_split = (in_imm[11:0] != '0);
          enc_last  = !enc_split;
        end
      end
      default: kind_ok = 1'b0;
    endcase

    if (!kind_ok) begin
      req_err = E_KIND;
    end else if (!funct_ok) begin
      req_err = E_FUNCT;
    end else if (!range_ok) begin
      req_err = E_RANGE;
    end else if (!align_ok) begin
      req_err = E_ALIGN;
    end else begin
      req_err = E_NONE;
    end
  end

  // Next-state: output slot, error pulse, counter and the pending LI low half.
  always_comb begin
    state_d     = state_q;
    li_rd_d     = li_rd_q;
    li_lo_d     = li_lo_q;
    out_valid_d = out_valid;
    out_insn_d  = out_insn;
    out_last_d  = out_last;
    err_valid_d = 1'b0;
    err_code_d  = err_code;
    count_d     = insn_count;

    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
      count_d     = insn_count + COUNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid && slot_free) begin
          if (req_err != E_NONE) begin
            err_valid_d = 1'b1;
            err_code_d  = req_err;
          end else begin
            out_valid_d = 1'b1;
            out_insn_d  = enc_insn;
            out_last_d  = enc_last;
            if (enc_split) begin
              state_d = S_LI_LO;
              li_rd_d = in_rd;
              li_lo_d = in_imm[11:0];
            end
          end
        end
      end
      S_LI_LO: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_insn_d  = {li_lo_q, li_rd_q, 3'b000, li_rd_q, OPC_OPIMM};
          out_last_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      li_rd_q    <= '0;
      li_lo_q    <= '0;
      out_valid  <= 1'b0;
      out_insn   <= '0;
      out_last   <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      insn_count <= '0;
    end else begin
      state_q    <= state_d;
      li_rd_q    <= li_rd_d;
      li_lo_q    <= li_lo_d;
      out_valid  <= out_valid_d;
      out_insn   <= out_insn_d;
      out_last   <= out_last_d;
      err_valid  <= err_valid_d;
      err_code   <= err_code_d;
      insn_count <= count_d;
    end
  end

endmodule
